// File: rtl/md_hilo_ctrl.sv
// rtl/md_hilo_ctrl.sv - multi-cycle multiply/divide sequencer owning the HI/LO register pair
//
// Parameters:
//   MUL_LAT   busy cycles for MULT/MULTU (1..4)
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   start     EX issue strobe, sampled only in IDLE
//   op        000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x ignored
//   A, B      forwarded rs / rt operands
//   flush     cancels any in-flight op (and any same-cycle issue)
//   rd_hi     selects HI (1) or LO (0) onto RHLOut
//   busy      registered, high while an op is in flight
//   done      one-cycle pulse after a MULT/DIV commit
//   RHLOut    combinational HI/LO read value
// Configuration macro:
//   MD_DIV_EARLY_EN  divides with |A| < |B| or B == 0 skip the iteration phase
module md_hilo_ctrl #(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        flush,
    input  logic        rd_hi,
    output logic        busy,
    output logic        done,
    output logic [31:0] RHLOut
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t      state;
    logic [31:0] hi, lo;
    logic [5:0]  cnt;
    logic [63:0] prod;
    logic [31:0] quo, rem, dvs, a_raw;
    logic        neg_q, neg_r, div0, early_r;

    // Operand conditioning for the issuing op.
    logic        is_signed, a_neg, b_neg, early_c;
    logic [31:0] a_mag, b_mag;
    logic [63:0] a_w, b_w, prod_c;

    assign is_signed = ~op[0];
    assign a_neg     = is_signed & A[31];
    assign b_neg     = is_signed & B[31];
    assign a_mag     = a_neg ? -A : A;
    assign b_mag     = b_neg ? -B : B;

    // 33-bit sign/zero extension; the low 64 bits of a 64x64 product are exact.
    assign a_w    = {{32{a_neg}}, A};
    assign b_w    = {{32{b_neg}}, B};
    assign prod_c = a_w * b_w;

`ifdef MD_DIV_EARLY_EN
    assign early_c = (B == 32'd0) || (a_mag < b_mag);
`else
    assign early_c = 1'b0;
`endif

    // One restoring-division step: shift the next dividend bit into the partial remainder.
    logic [32:0] tmp;
    logic        ge;
    logic [31:0] rem_next;

    assign tmp      = {rem, quo[31]};
    assign ge       = (tmp >= {1'b0, dvs});
    assign rem_next = ge ? (tmp[31:0] - dvs) : tmp[31:0];

    assign RHLOut = rd_hi ? hi : lo;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            hi      <= 32'd0;
            lo      <= 32'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            cnt     <= 6'd0;
            prod    <= 64'd0;
            quo     <= 32'd0;
            rem     <= 32'd0;
            dvs     <= 32'd0;
            a_raw   <= 32'd0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            div0    <= 1'b0;
            early_r <= 1'b0;
        end else if (flush) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            cnt   <= 6'd0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        case (op)
                            3'b000, 3'b001: begin
                                prod  <= prod_c;
                                cnt   <= 6'd0;
                                busy  <= 1'b1;
                                state <= S_MUL;
                            end
                            3'b010, 3'b011: begin
                                // Early path preloads the final quotient/remainder magnitudes.
                                quo     <= early_c ? 32'd0 : a_mag;
                                rem     <= early_c ? a_mag : 32'd0;
                                dvs     <= b_mag;
                                a_raw   <= A;
                                neg_q   <= a_neg ^ b_neg;
                                neg_r   <= a_neg;
                                div0    <= (B == 32'd0);
                                early_r <= early_c;
                                cnt     <= 6'd0;
                                busy    <= 1'b1;
                                state   <= S_DIV;
                            end
                            3'b100: hi <= A;
                            3'b101: lo <= A;
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    if (cnt == 6'(MUL_LAT - 1)) begin
                        hi    <= prod[63:32];
                        lo    <= prod[31:0];
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        cnt   <= 6'd0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 6'd1;
                    end
                end
                S_DIV: begin
                    if (early_r) begin
                        state <= S_FIX;
                    end else begin
                        rem <= rem_next;
                        quo <= {quo[30:0], ge};
                        if (cnt == 6'd31) begin
                            cnt   <= 6'd0;
                            state <= S_FIX;
                        end else begin
                            cnt <= cnt + 6'd1;
                        end
                    end
                end
                S_FIX: begin
                    if (div0) begin
                        lo <= 32'hFFFF_FFFF;
                        hi <= a_raw;
                    end else begin
                        lo <= neg_q ? -quo : quo;
                        hi <= neg_r ? -rem : rem;
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_md_hilo_ctrl.sv
// tb/tb_md_hilo_ctrl.sv - scoreboard testbench for md_hilo_ctrl
module tb_md_hilo_ctrl;

    localparam int MUL_LAT = 2;

    logic        clk = 1'b0;
    logic        rst, start, flush, rd_hi;
    logic [2:0]  op;
    logic [31:0] A, B;
    logic        busy, done;
    logic [31:0] RHLOut;

    md_hilo_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .A(A), .B(B),
        .flush(flush), .rd_hi(rd_hi), .busy(busy), .done(done), .RHLOut(RHLOut)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          kind;   // 0: immediate idle check, 1: wait for done
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          passes = 0;
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    function automatic logic [31:0] mag(input logic [31:0] v, input bit sgn);
        return (sgn && v[31]) ? 32'(0 - v) : v;
    endfunction

    // Reference result {HI, LO} from plain arithmetic.
    function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        int          sa, sb_;
        longint      la, lb, q, r;
        logic [63:0] p;
        sa = a; sb_ = b;
        la = sa; lb = sb_;
        case (o)
            3'd0: begin p = la * lb; return p; end
            3'd1: begin p = {32'd0, a} * {32'd0, b}; return p; end
            3'd2: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                q = la / lb; r = la % lb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        if (o <= 3'd1) return MUL_LAT;
`ifdef MD_DIV_EARLY_EN
        if (b == 0 || mag(a, !o[0]) < mag(b, !o[0])) return 2;
`endif
        return 33;
    endfunction

    // Monitor: owns rd_hi, reads both halves every cycle away from the active edge.
    int bcnt = 0;
    bit prev_done = 1'b0;
    initial begin
        logic [31:0] hv, lv;
        exp_t e;
        rd_hi = 1'b0;
        forever begin
            @(negedge clk);
            rd_hi = 1'b1; #1 hv = RHLOut;
            rd_hi = 1'b0; #1 lv = RHLOut;
            if (done) begin
                chk("done_single_pulse", {31'd0, prev_done}, 32'd0);
                if (sb.size() == 0 || sb[0].kind == 1'b0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("hi", hv, e.hi);
                    chk("lo", lv, e.lo);
                    chk("busy_cycles", bcnt, e.lat);
                end
                bcnt = 0;
            end else if (busy) begin
                bcnt++;
            end else begin
                bcnt = 0;
            end
            if (!done && sb.size() > 0 && sb[0].kind == 1'b0) begin
                e = sb.pop_front();
                chk("idle_hi", hv, e.hi);
                chk("idle_lo", lv, e.lo);
                chk("idle_busy", {31'd0, busy}, 32'd0);
            end
            prev_done = done;
        end
    end

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input bit push);
        logic [63:0] r;
        start = 1'b1; op = o; A = a; B = b;
        @(posedge clk); #1;
        start = 1'b0;
        if (push) begin
            if (o <= 3'd3) begin
                r = ref_result(o, a, b);
                m_hi = r[63:32]; m_lo = r[31:0];
                sb.push_back('{1'b1, m_hi, m_lo, ref_lat(o, a, b)});
                chk("busy_after_accept", {31'd0, busy}, 32'd1);
            end else begin
                if (o == 3'd4) m_hi = a;
                if (o == 3'd5) m_lo = a;
                sb.push_back('{1'b0, m_hi, m_lo, 0});
            end
        end
    endtask

    // Returns in the done cycle (posedge + 1) so the next issue is back-to-back.
    task automatic wait_done();
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (done) return;
        end
        chk("done_timeout", 32'd1, 32'd0);
    endtask

    task automatic push_idle_check();
        sb.push_back('{1'b0, m_hi, m_lo, 0});
        @(posedge clk); #1;
    endtask

    initial begin
        logic [2:0]  o;
        logic [31:0] a, b;
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = 3'd0; A = 32'd0; B = 32'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        push_idle_check();

        // Reset while mid-divide.
        issue(3'd4, 32'h1111_2222, 32'd0, 1);
        issue(3'd3, 32'd1000, 32'd3, 0);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        push_idle_check();

        issue(3'd4, 32'h1234_5678, 32'd0, 1);
        push_idle_check();

        issue(3'd0, 32'hFFFF_FFFD, 32'd5, 1); wait_done();
        issue(3'd1, 32'hFFFF_FFFD, 32'd5, 1); wait_done();
        issue(3'd3, 32'd100, 32'd7, 1);       wait_done();
        issue(3'd2, 32'hFFFF_FFF9, 32'd2, 1); wait_done();
        issue(3'd2, 32'd5, 32'd0, 1);         wait_done();
        issue(3'd3, 32'd3, 32'd10, 1);        wait_done();
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1); wait_done();
        // Back-to-back: MULT accepted in the DIV done cycle.
        issue(3'd2, 32'd77, 32'hFFFF_FFF5, 1); wait_done();
        issue(3'd0, 32'h0001_0000, 32'h0001_0000, 1); wait_done();

        // Flush in busy cycle 10 of a divide.
        @(posedge clk); #1;
        issue(3'd4, 32'hAAAA_0000, 32'd0, 1);
        issue(3'd5, 32'h0000_5555, 32'd0, 1);
        issue(3'd3, 32'd100, 32'd7, 0);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        chk("busy_after_flush", {31'd0, busy}, 32'd0);
        push_idle_check();
        repeat (40) @(posedge clk);
        #1;
        issue(3'd0, 32'd6, 32'hFFFF_FFF9, 1); wait_done();

        // Flush with start in IDLE suppresses MTHI.
        @(posedge clk); #1 flush = 1'b1;
        issue(3'd4, 32'hDEAD_BEEF, 32'd0, 0);
        flush = 1'b0;
        push_idle_check();

        // Ignored opcodes leave HI/LO alone.
        issue(3'd6, 32'h0BAD_0BAD, 32'd1, 1);
        issue(3'd7, 32'h0BAD_0BAD, 32'd1, 1);

        for (int n = 0; n < 30; n++) begin
            o = 3'($urandom_range(0, 5));
            a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            if ($urandom_range(0, 7) == 0) b = 32'd0;
            issue(o, a, b, 1);
            if (o <= 3'd3) wait_done();
        end

        repeat (5) @(posedge clk);
        #1 chk("scoreboard_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
